// File: rtl/fetch_decode_register.sv
// IF/ID pipeline register with 2-entry skid buffer and synchronous flush.
// Optional stall counter output enabled by FETCH_DECODE_STALL_COUNT_EN.
module fetch_decode_register #(
  parameter int PC_WIDTH          = 19,
  parameter int INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [PC_WIDTH-1:0]          inPC,
  input  logic [INSTRUCTION_WIDTH-1:0] inInstruction,
  input  logic                         inValid,
  output logic                         inReady,
  output logic [PC_WIDTH-1:0]          outPC,
  output logic [INSTRUCTION_WIDTH-1:0] outInstruction,
  output logic                         outValid,
`ifdef FETCH_DECODE_STALL_COUNT_EN
  output logic [31:0]                  stallCount,
`endif
  input  logic                         outReady
);

  // Encoding is {mainValid, skidValid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state, next;

  logic [PC_WIDTH-1:0]          main_pc, skid_pc;
  logic [INSTRUCTION_WIDTH-1:0] main_instr, skid_instr;

  logic accept, deliver;
  logic load_main_in, load_main_skid, clear_main;
  logic load_skid, clear_skid;

  assign inReady        = (state != FULL);
  assign outValid       = state[1];
  assign outPC          = main_pc;
  assign outInstruction = main_instr;

  assign accept  = inValid && inReady;
  assign deliver = outValid && outReady;

  always_comb begin
    next           = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      next       = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            next         = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            next      = FULL;
            load_skid = 1'b1;
          end else if (deliver) begin
            next       = EMPTY;
            clear_main = 1'b1;
          end
        end
        FULL: begin
          if (deliver) begin
            next           = ONE;
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
          end
        end
        default: begin
          next       = EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  // Data is zeroed whenever its valid drops so idle outputs read as NOP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state <= next;
      if (clear_main) begin
        main_pc    <= '0;
        main_instr <= '0;
      end else if (load_main_in) begin
        main_pc    <= inPC;
        main_instr <= inInstruction;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (clear_skid) begin
        skid_pc    <= '0;
        skid_instr <= '0;
      end else if (load_skid) begin
        skid_pc    <= inPC;
        skid_instr <= inInstruction;
      end
    end
  end

`ifdef FETCH_DECODE_STALL_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= '0;
    end else if (outValid && !outReady && stallCount != 32'hFFFF_FFFF) begin
      stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_register.sv
// Randomized + directed bench for fetch_decode_register.
// Reference model is a bounded FIFO queue of {pc, instr}.
module tb_fetch_decode_register;

  localparam int PW = 19;
  localparam int IW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [PW-1:0] inPC;
  logic [IW-1:0] inInstruction;
  logic          inValid;
  logic          inReady;
  logic [PW-1:0] outPC;
  logic [IW-1:0] outInstruction;
  logic          outValid;
  logic          outReady;
`ifdef FETCH_DECODE_STALL_COUNT_EN
  logic [31:0]   stallCount;
`endif

  fetch_decode_register #(.PC_WIDTH(PW), .INSTRUCTION_WIDTH(IW)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .inPC(inPC),
    .inInstruction(inInstruction),
    .inValid(inValid),
    .inReady(inReady),
    .outPC(outPC),
    .outInstruction(outInstruction),
    .outValid(outValid),
`ifdef FETCH_DECODE_STALL_COUNT_EN
    .stallCount(stallCount),
`endif
    .outReady(outReady)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] ins;
  } ent_t;

  ent_t        q[$];
  longint      m_stall;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk("outValid", 64'(outValid), 64'(q.size() > 0));
    chk("inReady", 64'(inReady), 64'(q.size() < 2));
    chk("outPC", 64'(outPC), 64'(h.pc));
    chk("outInstruction", 64'(outInstruction), 64'(h.ins));
`ifdef FETCH_DECODE_STALL_COUNT_EN
    chk("stallCount", 64'(stallCount), 64'(m_stall));
`endif
  endtask

  // Drive one cycle, advance the model at the edge, check at negedge.
  task automatic cycle(bit rst, bit fl, bit v, logic [PW-1:0] pc,
                       logic [IW-1:0] ins, bit ordy);
    bit dlv, acc;
    ent_t e;
    reset         = rst;
    flush         = fl;
    inValid       = v;
    inPC          = pc;
    inInstruction = ins;
    outReady      = ordy;
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !ordy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (fl) begin
        q.delete();
      end else begin
        dlv = (q.size() > 0) && ordy;
        acc = v && (q.size() < 2);
        if (dlv) void'(q.pop_front());
        if (acc) begin
          e.pc  = pc;
          e.ins = ins;
          q.push_back(e);
        end
      end
    end
    @(negedge clock);
    check_model();
  endtask

  initial begin
    m_stall = 0;
    cycle(1, 0, 0, '0, '0, 0);
    chk("reset_outValid", 64'(outValid), 64'd0);
    chk("reset_inReady", 64'(inReady), 64'd1);

    cycle(0, 0, 1, 19'h2, 32'h11800014, 1);
    chk("first_pc", 64'(outPC), 64'h2);
    chk("first_ins", 64'(outInstruction), 64'h11800014);

    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, PW'(i * 4), $urandom(), 1);
      chk("stream_pc", 64'(outPC), 64'(i * 4));
    end
    cycle(0, 0, 0, '0, '0, 1);

    cycle(0, 0, 1, 19'h10, $urandom(), 0);
    cycle(0, 0, 1, 19'h14, $urandom(), 0);
    chk("bp_inReady", 64'(inReady), 64'd0);
    chk("bp_pc", 64'(outPC), 64'h10);
    cycle(0, 0, 0, '0, '0, 1);
    chk("bp_drain_pc", 64'(outPC), 64'h14);
    chk("bp_ready_back", 64'(inReady), 64'd1);
    cycle(0, 0, 0, '0, '0, 1);

    cycle(0, 0, 1, 19'h30, $urandom(), 0);
    cycle(0, 0, 1, 19'h34, $urandom(), 0);
    cycle(0, 1, 1, 19'h18, $urandom(), 0);
    chk("flush_valid", 64'(outValid), 64'd0);
    chk("flush_ins", 64'(outInstruction), 64'd0);
    chk("flush_ready", 64'(inReady), 64'd1);
    cycle(0, 0, 0, '0, '0, 1);

    cycle(0, 0, 1, 19'h40, $urandom(), 0);
    cycle(0, 0, 1, 19'h44, $urandom(), 0);
    cycle(1, 0, 1, 19'h48, $urandom(), 1);
    chk("rst_pc", 64'(outPC), 64'd0);
    cycle(0, 0, 1, 19'h20, 32'hABCD, 1);
    chk("post_rst_pc", 64'(outPC), 64'h20);
    cycle(0, 0, 0, '0, '0, 1);

    cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 1, 19'h50, $urandom(), 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, '0, 0);
`ifdef FETCH_DECODE_STALL_COUNT_EN
    chk("stall5", 64'(stallCount), 64'd5);
    cycle(0, 1, 0, '0, '0, 1);
    chk("stall_flush", 64'(stallCount), 64'd5);
    cycle(1, 0, 0, '0, '0, 1);
    chk("stall_rst", 64'(stallCount), 64'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
            $urandom_range(0, 1), PW'($urandom()), $urandom(),
            ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
